// File: rtl/bf16_to_dec.sv
`default_nettype none
// ============================================================================
// bf16_to_dec : BF16 -> sign + 6-digit packed BCD (DDD.ddd), iterative  | rev 1.0
// ============================================================================
module bf16_to_dec #(
  parameter int BIN_W      = 20,
  parameter int BCD_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             a,
  input  logic                    error_in,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    neg,
  output logic                    error,
  output logic                    busy,
  output logic                    done
);

  localparam int          c_BCD_W     = 4 * BCD_DIGITS;
  localparam int          c_ITER_W    = $clog2(BIN_W);
  localparam int          c_SCL_W     = BIN_W + 2;
  localparam int          c_P_W       = 18;
  localparam logic [c_ITER_W-1:0] c_ITER_LAST = c_ITER_W'(BIN_W - 1);
  localparam logic [c_SCL_W-1:0]  c_MAX_N     = c_SCL_W'(999999);
  localparam logic [7:0]  c_EXP_MAX   = 8'hFF;
  localparam logic [7:0]  c_EXP_OVF   = 8'd137;
  localparam logic signed [8:0] c_K_BIAS = 9'sd134;
  localparam logic [8:0]  c_RSH_MAX   = 9'd17;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UNPACK  = 3'd1,
    S_SCALE   = 3'd2,
    S_CONVERT = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [15:0]           r_a;
  logic                  r_err_in;
  logic                  r_sign;
  logic                  r_err;
  logic [c_P_W-1:0]      r_p;
  logic signed [8:0]     r_k;
  logic [BIN_W-1:0]      r_n;
  logic                  r_nz;
  logic [c_BCD_W-1:0]    r_bcd_work;
  logic [c_ITER_W-1:0]   r_iter;
  logic [c_BCD_W-1:0]    r_bcd;
  logic                  r_neg;
  logic                  r_error;
  logic                  r_done;

  logic [7:0]            w_e;
  logic [c_P_W-1:0]      w_mant;
  logic [c_P_W-1:0]      w_p;
  logic signed [8:0]     w_k;
  logic                  w_unpack_err;
  logic [8:0]            w_rsh;
  logic [c_SCL_W-1:0]    w_p_ext;
  logic [c_SCL_W-1:0]    w_scaled;
  logic                  w_scale_ovf;
  logic [c_BCD_W-1:0]    w_bcd_adj;

  // --------------------------------------------------------------------------
  // Unpack: exponent >= 137 means |x| >= 1024, which cannot be shown as DDD.ddd
  // --------------------------------------------------------------------------
  assign w_e          = r_a[14:7];
  assign w_mant       = {10'd0, 1'b1, r_a[6:0]};
  assign w_p          = w_mant * c_P_W'(1000);
  assign w_k          = $signed({1'b0, w_e}) - c_K_BIAS;
  assign w_unpack_err = r_err_in | (w_e == c_EXP_MAX) | (w_e >= c_EXP_OVF);

  // Scale by 2^k with truncation; right shifts beyond the mantissa width give 0
  assign w_rsh    = 9'(-r_k);
  assign w_p_ext  = c_SCL_W'(r_p);
  always_comb begin
    w_scaled = '0;
    if (r_k[8]) begin
      if (w_rsh <= c_RSH_MAX) begin
        w_scaled = w_p_ext >> w_rsh;
      end
    end else begin
      w_scaled = w_p_ext << r_k[7:0];
    end
  end
  assign w_scale_ovf = (w_scaled > c_MAX_N);

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_dabble
      assign w_bcd_adj[4*gi +: 4] = (r_bcd_work[4*gi +: 4] >= 4'd5)
                                  ? r_bcd_work[4*gi +: 4] + 4'd3
                                  : r_bcd_work[4*gi +: 4];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_UNPACK;
      S_UNPACK:  w_state_nxt = w_unpack_err ? S_OUTPUT : S_SCALE;
      S_SCALE:   w_state_nxt = w_scale_ovf ? S_OUTPUT : S_CONVERT;
      S_CONVERT: if (r_iter == c_ITER_LAST) w_state_nxt = S_OUTPUT;
      S_OUTPUT:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_err_in   <= 1'b0;
      r_sign     <= 1'b0;
      r_err      <= 1'b0;
      r_p        <= '0;
      r_k        <= '0;
      r_n        <= '0;
      r_nz       <= 1'b0;
      r_bcd_work <= '0;
      r_iter     <= '0;
      r_bcd      <= '0;
      r_neg      <= 1'b0;
      r_error    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_err_in <= error_in;
          end
        end
        S_UNPACK: begin
          r_err <= w_unpack_err;
          // Zero and subnormals collapse to +0 so that -0 shows as +000.000
          if (w_e == 8'd0) begin
            r_sign <= 1'b0;
            r_p    <= '0;
            r_k    <= '0;
          end else begin
            r_sign <= r_a[15];
            r_p    <= w_p;
            r_k    <= w_k;
          end
        end
        S_SCALE: begin
          r_n        <= w_scaled[BIN_W-1:0];
          r_nz       <= (w_scaled != '0);
          r_err      <= w_scale_ovf;
          r_bcd_work <= '0;
          r_iter     <= '0;
        end
        S_CONVERT: begin
          {r_bcd_work, r_n} <= {w_bcd_adj[c_BCD_W-2:0], r_n, 1'b0};
          r_iter            <= r_iter + 1'b1;
        end
        S_OUTPUT: begin
          r_done <= 1'b1;
          if (r_err) begin
            r_bcd   <= '0;
            r_neg   <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_bcd   <= r_bcd_work;
            r_neg   <= r_sign & r_nz;
            r_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd   = r_bcd;
  assign neg   = r_neg;
  assign error = r_error;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: doc/bf16_to_dec.md
Name: bf16_to_dec

Overview:
Downstream formatter for BF16 results from the ALU function units (tan, sin, cos, divider). Converts a BF16 value plus an upstream error flag into sign + 6 packed-BCD digits (3 integer, 3 fraction, fixed point DDD.ddd) for the 7-segment display driver. Uses an iterative scale step followed by a 20-cycle double-dabble conversion, so one result is produced per request.

Parameters:
- BIN_W, 20, width of the scaled magnitude N = floor(|x|*1000); max 999999 fits.
- BCD_DIGITS, 6, number of BCD output digits (4 bits each).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- a  input  `INPUTOUTBIT (16)  BF16 value to format.
- error_in  input  1  upstream error flag (e.g. tan at ±90), sampled with start.
- bcd  output  24  packed BCD, bcd[23:20]=hundreds ... bcd[3:0]=thousandths.
- neg  output  1  sign of the displayed value.
- error  output  1  formatting/upstream error for this result.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when bcd/neg/error are updated.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state changes occur on posedge clk.
- Reset values: bcd=0, neg=0, error=0, done=0, busy=0, state=IDLE, internal registers 0. Asserting rst in any state, including mid-CONVERT, aborts the operation with no done pulse.
- bcd, neg and error hold their last values until the next done. Outputs are updated only on the done cycle.
- start is ignored while busy. a and error_in are latched on the cycle start is accepted.
- States: IDLE -> UNPACK -> SCALE -> CONVERT -> OUTPUT -> IDLE. An error short-circuits UNPACK -> OUTPUT.
- UNPACK (1 cycle): s=a[15], e=a[14:7], f=a[6:0].
  - Error if error_in=1, or e==255 (Inf/NaN), or e>=137 (|x|>=1024).
  - e==0 (zero/subnormal) gives N=0 and sign 0, so -0 displays as +000.000.
  - Otherwise P = {1,f} * 1000 (18-bit), k = e-127-7.
- SCALE (1 cycle):
  - k>=0: N = P<<k. k<0: N = P>>(-k), and N=0 when -k>17.
  - Truncation toward zero, no rounding.
  - If N>999999, set error and go to OUTPUT.
- CONVERT (exactly 20 cycles): double dabble on N.
  - Each cycle, add 3 to every BCD digit >=5, then shift {bcd_work,N} left by 1.
  - An iteration counter runs 0..19.
- OUTPUT (1 cycle): done=1.
  - Normal result: bcd=bcd_work, neg=s (0 when N==0), error=0.
  - Error result: bcd=0, neg=0, error=1.
- Latency, with start accepted at edge 0:
  - Normal path: done at edge 23 (UNPACK 1, SCALE 1, CONVERT 20, OUTPUT 1).
  - UNPACK error: done at edge 2.
  - SCALE overflow: done at edge 3.
  - busy is high edges 1..23 (normal path); IDLE is re-entered on the cycle after done.
- A start coincident with done/OUTPUT is ignored. It is accepted only when the state is IDLE.

Test Plan:
- a=16'h3F80 (1.0), error_in=0 -> done exactly 23 cycles after start, bcd=24'h001000, neg=0, error=0.
- a=16'hBF00 (-0.5) -> bcd=24'h000500, neg=1. a=16'h4265 (57.25) -> bcd=24'h057250, neg=0.
- a=16'h447A (1000.0) -> SCALE overflow, done 3 cycles after start, bcd=0, error=1. a=16'h7FC0 (NaN) -> done 2 cycles after start, error=1. a=16'h3F80 with error_in=1 -> error=1, bcd=0.
- a=16'h8000 and a=16'h0000 -> bcd=24'h000000, neg=0. a=16'h3A83 (~0.001) -> bcd=24'h000000 (truncation: 0.000999 floors to 0).
- Second start pulsed mid-CONVERT -> ignored: exactly one done, result of the first operand. Back-to-back starts are accepted only after busy drops.
- rst asserted at CONVERT iteration 10 -> next cycle busy=0, bcd=0, neg=0, error=0, no done. A fresh start then completes normally in 23 cycles.
